// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: button pulses in, timebase and BCD count out.
// The lap signal exists only when LAP_EN is defined.
interface stopwatch_ctrl_if;
    logic       strt_stp;
    logic       clr;
`ifdef LAP_EN
    logic       lap;
`endif
    logic       running;
    logic       tick;
    logic [7:0] hund;
    logic [7:0] sec;
    logic       ovf;

`ifdef LAP_EN
    modport master (
        output strt_stp, clr, lap,
        input  running, tick, hund, sec, ovf
    );
    modport slave (
        input  strt_stp, clr, lap,
        output running, tick, hund, sec, ovf
    );
`else
    modport master (
        output strt_stp, clr,
        input  running, tick, hund, sec, ovf
    );
    modport slave (
        input  strt_stp, clr,
        output running, tick, hund, sec, ovf
    );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear FSM, hundredth prescaler and BCD count.
// Optional lap hold compiled in with LAP_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 3,
    parameter int MAX_SEC  = 59
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0] SEC_MAX = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_FULL
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [7:0]    r_hund;
    logic [7:0]    r_sec;
    logic          r_ovf;
    logic          r_running;

    logic          w_tick;
    logic          w_sat;
    logic          w_hund_cy;
    logic [7:0]    w_hund_nx;
    logic [7:0]    w_sec_nx;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = v[7:4];
        o = v[3:0];
        if (o == 4'd9) begin
            o = 4'd0;
            t = (t == 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            o = o + 4'd1;
        end
        return {t, o};
    endfunction

    assign w_tick    = (r_state == S_RUN) && (r_pre == PRE_MAX);
    assign w_sat     = (r_sec == SEC_MAX) && (r_hund == 8'h99);
    assign w_hund_cy = (r_hund == 8'h99);
    assign w_hund_nx = bcd_inc(r_hund);
    assign w_sec_nx  = bcd_inc(r_sec);

    // FSM, prescaler and cascaded BCD count; saturating tick wins over strt_stp
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_hund    <= 8'h00;
            r_sec     <= 8'h00;
            r_ovf     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.strt_stp) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        r_pre <= '0;
                        if (w_sat) begin
                            r_state   <= S_FULL;
                            r_running <= 1'b0;
                            r_ovf     <= 1'b1;
                        end else begin
                            r_hund <= w_hund_nx;
                            if (w_hund_cy) begin
                                r_sec <= w_sec_nx;
                            end
                            if (bus.strt_stp) begin
                                r_state   <= S_PAUSE;
                                r_running <= 1'b0;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                        if (bus.strt_stp) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.strt_stp) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_FULL: begin
                    r_state <= S_FULL;
                end
            endcase
        end
    end

`ifdef LAP_EN
    logic       r_hold;
    logic [7:0] r_lap_hund;
    logic [7:0] r_lap_sec;
    logic       w_lap_ok;

    assign w_lap_ok = (r_state == S_RUN) || (r_state == S_PAUSE);

    // Lap hold: freeze displayed value while the live count keeps going
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_hold     <= 1'b0;
            r_lap_hund <= 8'h00;
            r_lap_sec  <= 8'h00;
        end else if (w_tick && w_sat) begin
            r_hold <= 1'b0;
        end else if (bus.lap && w_lap_ok) begin
            if (!r_hold) begin
                r_hold     <= 1'b1;
                r_lap_hund <= r_hund;
                r_lap_sec  <= r_sec;
            end else begin
                r_hold <= 1'b0;
            end
        end
    end

    assign bus.hund = r_hold ? r_lap_hund : r_hund;
    assign bus.sec  = r_hold ? r_lap_sec  : r_sec;
`else
    assign bus.hund = r_hund;
    assign bus.sec  = r_sec;
`endif

    assign bus.tick    = w_tick;
    assign bus.running = r_running;
    assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: TICK_DIV=3/MAX_SEC=1 and
// TICK_DIV=1/MAX_SEC=10 instances, optional lap checks under LAP_EN.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl_if sw ();
    stopwatch_ctrl_if sw2 ();

    stopwatch_ctrl #(.TICK_DIV(3), .MAX_SEC(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    stopwatch_ctrl #(.TICK_DIV(1), .MAX_SEC(10)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (sw2)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start1();
        sw.strt_stp = 1'b1;
        step(1);
        sw.strt_stp = 1'b0;
    endtask

    task automatic clear1();
        sw.clr = 1'b1;
        step(1);
        sw.clr = 1'b0;
    endtask

    initial begin
        sw.strt_stp  = 1'b0;
        sw.clr       = 1'b0;
        sw2.strt_stp = 1'b0;
        sw2.clr      = 1'b0;
`ifdef LAP_EN
        sw.lap       = 1'b0;
        sw2.lap      = 1'b0;
`endif
        #1;
        // 1: reset state and idle
        step(2);
        chk("rst_hund", sw.hund, 8'h00);
        chk("rst_sec", sw.sec, 8'h00);
        chk("rst_ovf", {7'd0, sw.ovf}, 8'd0);
        chk("rst_run", {7'd0, sw.running}, 8'd0);
        chk("rst_tick", {7'd0, sw.tick}, 8'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("idle_tick", {7'd0, sw.tick}, 8'd0);
            step(1);
        end
        // 2: 30 RUN cycles, tick every 3rd
        start1();
        for (int k = 0; k < 30; k++) begin
            chk("run_tick", {7'd0, sw.tick}, {7'd0, (k % 3) == 2});
            step(1);
        end
        chk("run_hund", sw.hund, 8'h10);
        chk("run_sec", sw.sec, 8'h00);
        chk("run_running", {7'd0, sw.running}, 8'd1);
        // 3: pause retains prescaler
        clear1();
        chk("clr_hund", sw.hund, 8'h00);
        start1();
        step(13);
        sw.strt_stp = 1'b1;
        step(1);
        sw.strt_stp = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("pause_tick", {7'd0, sw.tick}, 8'd0);
            step(1);
        end
        chk("pause_hund", sw.hund, 8'h04);
        chk("pause_run", {7'd0, sw.running}, 8'd0);
        start1();
        chk("resume_run", {7'd0, sw.running}, 8'd1);
        chk("resume_tick", {7'd0, sw.tick}, 8'd1);
        step(1);
        chk("resume_hund", sw.hund, 8'h05);
        // 4: BCD carries over 100 ticks
        clear1();
        start1();
        for (int i = 1; i <= 100; i++) begin
            step(3);
            if (i == 9)   chk("c9_hund", sw.hund, 8'h09);
            if (i == 10)  chk("c10_hund", sw.hund, 8'h10);
            if (i == 99)  chk("c99_hund", sw.hund, 8'h99);
            if (i == 99)  chk("c99_sec", sw.sec, 8'h00);
            if (i == 100) chk("c100_hund", sw.hund, 8'h00);
            if (i == 100) chk("c100_sec", sw.sec, 8'h01);
        end
        // 5: saturation with simultaneous strt_stp
        step(297);
        chk("sat_pre_sec", sw.sec, 8'h01);
        chk("sat_pre_hund", sw.hund, 8'h99);
        step(2);
        chk("sat_tick", {7'd0, sw.tick}, 8'd1);
        sw.strt_stp = 1'b1;
        step(1);
        sw.strt_stp = 1'b0;
        chk("full_ovf", {7'd0, sw.ovf}, 8'd1);
        chk("full_run", {7'd0, sw.running}, 8'd0);
        chk("full_hund", sw.hund, 8'h99);
        chk("full_sec", sw.sec, 8'h01);
        chk("full_tick", {7'd0, sw.tick}, 8'd0);
        start1();
        step(5);
        chk("full_ss_run", {7'd0, sw.running}, 8'd0);
        chk("full_ss_tick", {7'd0, sw.tick}, 8'd0);
        chk("full_ss_hund", sw.hund, 8'h99);
        clear1();
        chk("fclr_hund", sw.hund, 8'h00);
        chk("fclr_sec", sw.sec, 8'h00);
        chk("fclr_ovf", {7'd0, sw.ovf}, 8'd0);
        chk("fclr_run", {7'd0, sw.running}, 8'd0);
        // tick with strt_stp: advance and pause together
        start1();
        step(2);
        chk("tp_tick", {7'd0, sw.tick}, 8'd1);
        sw.strt_stp = 1'b1;
        step(1);
        sw.strt_stp = 1'b0;
        chk("tp_hund", sw.hund, 8'h01);
        chk("tp_run", {7'd0, sw.running}, 8'd0);
        clear1();
        // 6: clr beats strt_stp and tick
        start1();
        step(2);
        chk("cs_tick", {7'd0, sw.tick}, 8'd1);
        sw.clr      = 1'b1;
        sw.strt_stp = 1'b1;
        step(1);
        sw.clr      = 1'b0;
        sw.strt_stp = 1'b0;
        chk("cs_hund", sw.hund, 8'h00);
        chk("cs_sec", sw.sec, 8'h00);
        chk("cs_run", {7'd0, sw.running}, 8'd0);
        chk("cs_tick0", {7'd0, sw.tick}, 8'd0);
        start1();
        for (int k = 0; k < 3; k++) begin
            chk("cs_pre", {7'd0, sw.tick}, {7'd0, k == 2});
            step(1);
        end
        chk("cs_hund1", sw.hund, 8'h01);
`ifdef LAP_EN
        clear1();
        start1();
        step(60);
        chk("lap_hund0", sw.hund, 8'h20);
        sw.lap = 1'b1;
        step(1);
        sw.lap = 1'b0;
        step(44);
        chk("lap_hold", sw.hund, 8'h20);
        chk("lap_hold_sec", sw.sec, 8'h00);
        sw.lap = 1'b1;
        step(1);
        sw.lap = 1'b0;
        chk("lap_live", sw.hund, 8'h35);
`endif
        // TICK_DIV=1, MAX_SEC=10: tick every cycle, seconds tens carry
        sw2.strt_stp = 1'b1;
        step(1);
        sw2.strt_stp = 1'b0;
        chk("d1_tick", {7'd0, sw2.tick}, 8'd1);
        step(999);
        chk("d1_sec9", sw2.sec, 8'h09);
        chk("d1_hund9", sw2.hund, 8'h99);
        step(100);
        chk("d1_sec10", sw2.sec, 8'h10);
        chk("d1_hund99", sw2.hund, 8'h99);
        chk("d1_tick_sat", {7'd0, sw2.tick}, 8'd1);
        step(1);
        chk("d1_ovf", {7'd0, sw2.ovf}, 8'd1);
        chk("d1_full_sec", sw2.sec, 8'h10);
        chk("d1_full_hund", sw2.hund, 8'h99);
        chk("d1_full_tick", {7'd0, sw2.tick}, 8'd0);
        chk("d1_full_run", {7'd0, sw2.running}, 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
